// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   pc_state_e        sequencer state encodings (RUN/DM_WAIT/DRAIN/TAKE)
//   DEF_DRAIN_CYCLES  default bubble count before an interrupt is taken
//   DRAIN_CNT_W       width of the drain counter (covers 1..7 cycles)
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_RUN     = 2'd0,
      PC_DM_WAIT = 2'd1,
      PC_DRAIN   = 2'd2,
      PC_TAKE    = 2'd3
   } pc_state_e;

   localparam int unsigned DEF_DRAIN_CYCLES = 3;
   localparam int unsigned DRAIN_CNT_W      = 3;

endpackage

// File: rtl/pipe_ctrl_satcnt.sv
// pipe_ctrl_satcnt: CNT_W-bit up counter that sticks at all-ones.
//   clk  in   core clock
//   rst  in   asynchronous active-high reset, clears the count
//   inc  in   count this cycle
//   cnt  out  current count
module pipe_ctrl_satcnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline.
//   clk, rst                 clock, asynchronous active-high reset
//   do_hazard                load-use hazard for the instruction in ID
//   do_jump                  taken jump/branch resolved in EX
//   dm_access, dm_ack        MEM-stage data access and its completion
//   irq_req                  level interrupt request
//   irq_take                 one-cycle pulse, PC loads the vector
//   pc_en, xreg1..4_en       PC / pipeline register load enables
//   xreg1_flush, xreg2_flush bubble insert into IF/ID and ID/EX
//   stall_cnt, flush_cnt     saturating performance counters
//   state                    current sequencer state (debug)
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             do_hazard,
   input  logic             do_jump,
   input  logic             dm_access,
   input  logic             dm_ack,
   input  logic             irq_req,
   output logic             irq_take,
   output logic             pc_en,
   output logic             xreg1_en,
   output logic             xreg2_en,
   output logic             xreg3_en,
   output logic             xreg4_en,
   output logic             xreg1_flush,
   output logic             xreg2_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       state
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   pc_state_e              state_q, state_d;
   logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
   logic                   irq_take_q;
   logic                   dm_stall;
   logic                   jump_acc;
   logic                   stall_inc;

   always_comb begin
      dm_stall    = dm_access & ~dm_ack;
      pc_en       = 1'b1;
      xreg1_en    = 1'b1;
      xreg2_en    = 1'b1;
      xreg3_en    = 1'b1;
      xreg4_en    = 1'b1;
      xreg1_flush = 1'b0;
      xreg2_flush = 1'b0;
      jump_acc    = 1'b0;
      state_d     = state_q;
      drain_d     = drain_q;

      case (state_q)
         // RUN and the ack cycle of DM_WAIT share the same priority chain;
         // only RUN may accept an interrupt.
         PC_RUN, PC_DM_WAIT: begin
            if ((state_q == PC_RUN) ? dm_stall : !dm_ack) begin
               pc_en    = 1'b0;
               xreg1_en = 1'b0;
               xreg2_en = 1'b0;
               xreg3_en = 1'b0;
               xreg4_en = 1'b0;
               state_d  = PC_DM_WAIT;
            end else begin
               state_d = PC_RUN;
               if (do_jump) begin
                  xreg1_flush = 1'b1;
                  xreg2_flush = 1'b1;
                  jump_acc    = 1'b1;
               end else if (do_hazard) begin
                  pc_en       = 1'b0;
                  xreg1_en    = 1'b0;
                  xreg2_flush = 1'b1;
               end else if (irq_req && (state_q == PC_RUN)) begin
                  pc_en       = 1'b0;
                  xreg1_flush = 1'b1;
                  drain_d     = DRAIN_LOAD;
                  state_d     = PC_DRAIN;
               end
            end
         end

         PC_DRAIN: begin
            if (dm_stall) begin
               pc_en    = 1'b0;
               xreg1_en = 1'b0;
               xreg2_en = 1'b0;
               xreg3_en = 1'b0;
               xreg4_en = 1'b0;
            end else begin
               // A jump here loads its target, which becomes the return PC.
               pc_en       = do_jump;
               xreg1_flush = 1'b1;
               xreg2_flush = do_jump;
               jump_acc    = do_jump;
               // The acceptance cycle already inserted one bubble, so the
               // last DRAIN cycle is the one where the counter steps 1->0.
               if (drain_q <= DRAIN_CNT_W'(1)) begin
                  drain_d = '0;
                  state_d = PC_TAKE;
               end else begin
                  drain_d = drain_q - DRAIN_CNT_W'(1);
               end
            end
         end

         PC_TAKE: begin
            xreg1_flush = 1'b1;
            state_d     = PC_RUN;
         end

         default: begin
            state_d = PC_RUN;
         end
      endcase

      if (rst) begin
         pc_en       = 1'b0;
         xreg1_en    = 1'b0;
         xreg2_en    = 1'b0;
         xreg3_en    = 1'b0;
         xreg4_en    = 1'b0;
         xreg1_flush = 1'b1;
         xreg2_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= PC_RUN;
         drain_q    <= '0;
         irq_take_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         irq_take_q <= (state_d == PC_TAKE);
      end
   end

   assign irq_take  = irq_take_q;
   assign state     = state_q;
   assign stall_inc = ~pc_en & ~rst;

   pipe_ctrl_satcnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   pipe_ctrl_satcnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (jump_acc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a
// behavioural model of the sequencing rules (CNT_W=4, DRAIN_CYCLES=3).
module tb_pipe_ctrl;

   localparam int CW  = 4;
   localparam int DC  = 3;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          do_hazard = 1'b0, do_jump = 1'b0, dm_access = 1'b0;
   logic          dm_ack = 1'b0, irq_req = 1'b0;
   logic          irq_take, pc_en, xreg1_en, xreg2_en, xreg3_en, xreg4_en;
   logic          xreg1_flush, xreg2_flush;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [1:0]    state;

   int n_assert = 0;
   int n_fail   = 0;

   // model: waiting on memory, drain cycles still to run, take due
   bit m_wait;
   int m_drain;
   bit m_take;
   int m_stall;
   int m_flush;

   pipe_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
      .clk         (clk),
      .rst         (rst),
      .do_hazard   (do_hazard),
      .do_jump     (do_jump),
      .dm_access   (dm_access),
      .dm_ack      (dm_ack),
      .irq_req     (irq_req),
      .irq_take    (irq_take),
      .pc_en       (pc_en),
      .xreg1_en    (xreg1_en),
      .xreg2_en    (xreg2_en),
      .xreg3_en    (xreg3_en),
      .xreg4_en    (xreg4_en),
      .xreg1_flush (xreg1_flush),
      .xreg2_flush (xreg2_flush),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctl_vec();
      return {pc_en, xreg1_en, xreg2_en, xreg3_en, xreg4_en, xreg1_flush, xreg2_flush, irq_take};
   endfunction

   // Called at a falling edge: drive inputs, compare against the model,
   // advance the model, then move to the next falling edge.
   task automatic step(input logic h, input logic j, input logic a, input logic k,
                       input logic i, output logic pc_o, output logic tk_o);
      logic e_pc, e1, e2, e3, e4, ef1, ef2, etk, acc_j, stall;
      logic [1:0] est;
      bit was_wait;
      do_hazard = h; do_jump = j; dm_access = a; dm_ack = k; irq_req = i;
      #1;
      stall = a & ~k;
      {e_pc, e1, e2, e3, e4} = '1;
      ef1 = 1'b0; ef2 = 1'b0; etk = 1'b0; acc_j = 1'b0;
      est = m_take ? 2'd3 : (m_drain > 0) ? 2'd2 : m_wait ? 2'd1 : 2'd0;
      if (m_take) begin
         etk = 1'b1; ef1 = 1'b1; m_take = 1'b0;
      end else if (m_drain > 0) begin
         if (stall) begin
            {e_pc, e1, e2, e3, e4} = '0;
         end else begin
            e_pc = j; ef1 = 1'b1; ef2 = j; acc_j = j;
            m_drain--;
            if (m_drain == 0) m_take = 1'b1;
         end
      end else if (m_wait ? !k : stall) begin
         {e_pc, e1, e2, e3, e4} = '0;
         m_wait = 1'b1;
      end else begin
         was_wait = m_wait;
         m_wait = 1'b0;
         if (j) begin
            ef1 = 1'b1; ef2 = 1'b1; acc_j = 1'b1;
         end else if (h) begin
            e_pc = 1'b0; e1 = 1'b0; ef2 = 1'b1;
         end else if (i && !was_wait) begin
            e_pc = 1'b0; ef1 = 1'b1; m_drain = DC - 1;
         end
      end
      chk("ctl", 32'(ctl_vec()), 32'({e_pc, e1, e2, e3, e4, ef1, ef2, etk}));
      chk("state", 32'(state), 32'(est));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (!e_pc && m_stall < SAT) m_stall++;
      if (acc_j && m_flush < SAT) m_flush++;
      pc_o = pc_en;
      tk_o = irq_take;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset applied at a falling edge, checked before any clock.
   task automatic do_reset();
      rst = 1'b1;
      do_hazard = 1'b0; do_jump = 1'b0; dm_access = 1'b0; dm_ack = 1'b0; irq_req = 1'b0;
      #1;
      chk("rst_ctl", 32'(ctl_vec()), 32'h06);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      m_wait = 1'b0; m_drain = 0; m_take = 1'b0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic pc_o, tk_o;
      int first, ntake, pc0;

      @(negedge clk);
      do_reset();

      // load-use hazard
      step(1, 0, 0, 0, 0, pc_o, tk_o);
      chk("lu_pc_en", 32'(pc_o), 32'd0);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      step(0, 0, 0, 0, 0, pc_o, tk_o);

      // jump and hazard together: jump wins
      step(1, 1, 0, 0, 0, pc_o, tk_o);
      chk("jh_pc_en", 32'(pc_o), 32'd1);
      chk("jh_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("jh_stall_cnt", 32'(stall_cnt), 32'd1);

      // data-memory wait of 3 cycles
      do_reset();
      for (int n = 0; n < 3; n++) step(0, 0, 1, 0, 0, pc_o, tk_o);
      step(0, 0, 1, 1, 0, pc_o, tk_o);
      chk("dm_ack_pc_en", 32'(pc_o), 32'd1);
      chk("dm_stall_cnt", 32'(stall_cnt), 32'd3);

      // interrupt entry
      do_reset();
      step(0, 0, 0, 0, 1, pc_o, tk_o);
      pc0 = pc_o ? 0 : 1; first = -1; ntake = 0;
      for (int n = 1; n <= 10; n++) begin
         step(0, 0, 0, 0, 0, pc_o, tk_o);
         if (tk_o) begin
            ntake++;
            if (first < 0) first = n;
         end else if (first < 0 && !pc_o) begin
            pc0++;
         end
      end
      chk("irq_at", 32'(first), 32'd3);
      chk("irq_once", 32'(ntake), 32'd1);
      chk("irq_pc_stalls", 32'(pc0), 32'd3);
      chk("irq_state_end", 32'(state), 32'd0);

      // memory stall inside DRAIN delays the take by 2
      do_reset();
      step(0, 0, 0, 0, 1, pc_o, tk_o);
      first = -1;
      step(0, 0, 1, 0, 0, pc_o, tk_o);
      step(0, 0, 1, 0, 0, pc_o, tk_o);
      for (int n = 3; n <= 10; n++) begin
         step(0, 0, 0, 0, 0, pc_o, tk_o);
         if (tk_o && first < 0) first = n;
      end
      chk("irq_dm_at", 32'(first), 32'd5);

      // stall counter saturation
      do_reset();
      for (int n = 0; n < 20; n++) step(1, 0, 0, 0, 0, pc_o, tk_o);
      chk("stall_sat", 32'(stall_cnt), 32'd15);

      // reset in the middle of DRAIN aborts the interrupt
      do_reset();
      step(0, 0, 0, 0, 1, pc_o, tk_o);
      step(0, 0, 0, 0, 0, pc_o, tk_o);
      chk("mid_drain_state", 32'(state), 32'd2);
      do_reset();
      ntake = 0;
      for (int n = 0; n < 6; n++) begin
         step(0, 0, 0, 0, 0, pc_o, tk_o);
         if (tk_o) ntake++;
      end
      chk("mid_drain_no_take", 32'(ntake), 32'd0);

      // random traffic against the model
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int n = 0; n < 100; n++) begin
            step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 5) == 0),
                 logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) == 0), pc_o, tk_o);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
